tone_sweep_ctrl: RTL and testbench

TONE_SWEEP_CTRL -- requirements
Module: tone_sweep_ctrl

---
 rtl/tone_sweep_pkg.sv | 17 +
 rtl/sweep_timer.sv | 31 +++
 rtl/tone_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_tone_sweep_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_sweep_pkg.sv
// Shared types and default widths for the tone sweep controller.
package tone_sweep_pkg;

  localparam int PHASE_W = 24;
  localparam int AMPL_W  = 10;
  localparam int TIME_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DWELL  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } sweep_state_e;

endpackage

// File: rtl/sweep_timer.sv
// Down-counter shared by the settle and dwell phases.
// expired is high while the count is on its last cycle (or already empty).
module sweep_timer #(
  parameter int TIME_W = tone_sweep_pkg::TIME_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TIME_W-1:0] value,
  input  logic              tick_en,
  output logic              expired
);

  logic [TIME_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = value;
    else if (tick_en && count_q != '0)
      count_d = count_q - TIME_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = (count_q <= TIME_W'(1));

endmodule

// File: rtl/tone_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for an NCO: per tone, settle then dwell
// with meas_valid, stepping the phase increment between tones. All outputs registered.
module tone_sweep_ctrl #(
  parameter int PHASE_W = tone_sweep_pkg::PHASE_W,
  parameter int AMPL_W  = tone_sweep_pkg::AMPL_W,
  parameter int TIME_W  = tone_sweep_pkg::TIME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] cfg_f_start,
  input  logic [PHASE_W-1:0] cfg_f_step,
  input  logic [7:0]         cfg_n_steps,
  input  logic [TIME_W-1:0]  cfg_settle,
  input  logic [TIME_W-1:0]  cfg_dwell,
  input  logic [AMPL_W-1:0]  cfg_ampl,
  output logic [PHASE_W-1:0] phase_inc,
  output logic [AMPL_W-1:0]  ampl,
  output logic               nco_en,
  output logic               meas_valid,
  output logic [7:0]         step_idx,
  output logic               busy,
  output logic               done,
  output logic               aborted
);
  import tone_sweep_pkg::*;

  sweep_state_e       state_q, state_d;
  logic [1:0]         rst_sync_q;
  logic [PHASE_W-1:0] f_step_q, phase_inc_q, phase_inc_d;
  logic [7:0]         n_steps_q, step_idx_q, step_idx_d, last_idx;
  logic [TIME_W-1:0]  settle_q, dwell_q, dwell_eff, tmr_value;
  logic [AMPL_W-1:0]  ampl_q, ampl_d;
  logic               nco_en_q, nco_en_d, meas_valid_q, meas_valid_d;
  logic               busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic               run_ok, tmr_load, tmr_tick, tmr_expired;

  // Reset asserts asynchronously but releases start only after two clean edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run_ok = rst_sync_q[1];

  assign dwell_eff = (dwell_q == '0) ? TIME_W'(1) : dwell_q;
  assign last_idx  = (n_steps_q == 8'd0) ? 8'd0 : n_steps_q - 8'd1;

  // State register plus latched configuration and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      f_step_q     <= '0;
      n_steps_q    <= '0;
      settle_q     <= '0;
      dwell_q      <= '0;
      phase_inc_q  <= '0;
      ampl_q       <= '0;
      step_idx_q   <= '0;
      nco_en_q     <= 1'b0;
      meas_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_LOAD) begin
        f_step_q  <= cfg_f_step;
        n_steps_q <= cfg_n_steps;
        settle_q  <= cfg_settle;
        dwell_q   <= cfg_dwell;
      end
      phase_inc_q  <= phase_inc_d;
      ampl_q       <= ampl_d;
      step_idx_q   <= step_idx_d;
      nco_en_q     <= nco_en_d;
      meas_valid_q <= meas_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:          if (start && !abort && run_ok) state_d = ST_LOAD;
      ST_LOAD, ST_NEXT: state_d = (settle_q == '0) ? ST_DWELL : ST_SETTLE;
      ST_SETTLE:        if (tmr_expired) state_d = ST_DWELL;
      ST_DWELL:         if (tmr_expired) state_d = (step_idx_q == last_idx) ? ST_DONE : ST_NEXT;
      ST_DONE:          state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    phase_inc_d = phase_inc_q;
    ampl_d      = ampl_q;
    step_idx_d  = step_idx_q;
    if (state_d == ST_LOAD) begin
      phase_inc_d = cfg_f_start;
      ampl_d      = cfg_ampl;
      step_idx_d  = 8'd0;
    end else if (state_d == ST_NEXT) begin
      phase_inc_d = phase_inc_q + f_step_q;
      step_idx_d  = step_idx_q + 8'd1;
    end
    nco_en_d     = (state_d inside {ST_LOAD, ST_SETTLE, ST_DWELL, ST_NEXT});
    meas_valid_d = (state_d == ST_DWELL);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    aborted_d    = abort && (state_q != ST_IDLE);
  end

  assign tmr_load  = (state_d == ST_SETTLE && state_q != ST_SETTLE) ||
                     (state_d == ST_DWELL  && state_q != ST_DWELL);
  assign tmr_value = (state_d == ST_SETTLE) ? settle_q : dwell_eff;
  assign tmr_tick  = (state_q == ST_SETTLE) || (state_q == ST_DWELL);

  sweep_timer #(.TIME_W(TIME_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .tick_en (tmr_tick),
    .expired (tmr_expired)
  );

  assign phase_inc  = phase_inc_q;
  assign ampl       = ampl_q;
  assign step_idx   = step_idx_q;
  assign nco_en     = nco_en_q;
  assign meas_valid = meas_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// Directed bench for tone_sweep_ctrl: basic sweep, zero settings, wrap, abort,
// mid-sweep reset, ignored cfg/start changes, start/abort interplay in IDLE.
module tb_tone_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [23:0] cfg_f_start, cfg_f_step;
  logic [7:0]  cfg_n_steps;
  logic [15:0] cfg_settle, cfg_dwell;
  logic [9:0]  cfg_ampl;
  logic [23:0] phase_inc;
  logic [9:0]  ampl;
  logic        nco_en, meas_valid, busy, done, aborted;
  logic [7:0]  step_idx;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int d0, a0;
  logic [23:0] ph_exp [3] = '{24'h001000, 24'h001800, 24'h002000};

  tone_sweep_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_f_start(cfg_f_start), .cfg_f_step(cfg_f_step), .cfg_n_steps(cfg_n_steps),
    .cfg_settle(cfg_settle), .cfg_dwell(cfg_dwell), .cfg_ampl(cfg_ampl),
    .phase_inc(phase_inc), .ampl(ampl), .nco_en(nco_en), .meas_valid(meas_valid),
    .step_idx(step_idx), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1)    done_cnt++;
    if (aborted === 1'b1) abort_cnt++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_phase"}, 32'(phase_inc), 32'h0);
    chk({tag, "_ampl"}, 32'(ampl), 32'h0);
    chk({tag, "_nco_en"}, 32'(nco_en), 32'h0);
    chk({tag, "_meas"}, 32'(meas_valid), 32'h0);
    chk({tag, "_step"}, 32'(step_idx), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_aborted"}, 32'(aborted), 32'h0);
  endtask

  task automatic set_cfg(input logic [23:0] fs, input logic [23:0] fst, input logic [7:0] n,
                         input logic [15:0] st, input logic [15:0] dw);
    cfg_f_start = fs; cfg_f_step = fst; cfg_n_steps = n; cfg_settle = st; cfg_dwell = dw;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_ampl = 10'h2A5;
    set_cfg(24'h0, 24'h0, 8'd0, 16'd0, 16'd0);
    #1 reset = 1'b1;
    #1 chk_rst("reset");
    cyc(2); reset = 1'b0; cyc(3);

    // Basic sweep: 3 tones, settle 4, dwell 8.
    set_cfg(24'h001000, 24'h000800, 8'd3, 16'd4, 16'd8);
    d0 = done_cnt; start = 1'b1;
    cyc(); start = 1'b0;
    chk("b_load_phase", 32'(phase_inc), 32'h001000);
    chk("b_load_ampl", 32'(ampl), 32'h2A5);
    chk("b_load_nco", 32'(nco_en), 32'h1);
    chk("b_load_busy", 32'(busy), 32'h1);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(); chk("b_settle_meas", 32'(meas_valid), 32'h0);
      end
      for (int i = 0; i < 8; i++) begin
        cyc();
        chk("b_dwell_meas", 32'(meas_valid), 32'h1);
        chk("b_dwell_phase", 32'(phase_inc), 32'(ph_exp[t]));
        chk("b_dwell_step", 32'(step_idx), 32'(t));
      end
      cyc();
      if (t < 2) begin
        chk("b_next_meas", 32'(meas_valid), 32'h0);
        chk("b_next_phase", 32'(phase_inc), 32'(ph_exp[t+1]));
        chk("b_next_step", 32'(step_idx), 32'(t + 1));
      end else begin
        chk("b_done", 32'(done), 32'h1);
        chk("b_done_nco", 32'(nco_en), 32'h0);
      end
    end
    cyc();
    chk("b_idle_done", 32'(done), 32'h0);
    chk("b_idle_busy", 32'(busy), 32'h0);
    chk("b_idle_phase_hold", 32'(phase_inc), 32'h002000);
    chk("b_done_count", 32'(done_cnt - d0), 32'h1);

    // Zero settle/dwell/n_steps: one tone, one measurement cycle.
    set_cfg(24'h000400, 24'h000100, 8'd0, 16'd0, 16'd0);
    d0 = done_cnt; start = 1'b1;
    cyc(); start = 1'b0;
    chk("z_load_meas", 32'(meas_valid), 32'h0);
    cyc(); chk("z_dwell_meas", 32'(meas_valid), 32'h1);
    cyc(); chk("z_done", 32'(done), 32'h1);
    chk("z_done_meas", 32'(meas_valid), 32'h0);
    cyc(); chk("z_idle_busy", 32'(busy), 32'h0);
    chk("z_done_count", 32'(done_cnt - d0), 32'h1);

    // Phase wrap modulo 2^24.
    set_cfg(24'hFFFF00, 24'h000200, 8'd2, 16'd0, 16'd1);
    start = 1'b1;
    cyc(); start = 1'b0;
    chk("w_first_phase", 32'(phase_inc), 32'hFFFF00);
    cyc(2);
    chk("w_wrap_phase", 32'(phase_inc), 32'h000100);
    chk("w_wrap_step", 32'(step_idx), 32'h1);
    cyc(2); chk("w_done", 32'(done), 32'h1);
    cyc(); chk("w_idle_phase_hold", 32'(phase_inc), 32'h000100);

    // Abort on the final dwell cycle of the last tone.
    set_cfg(24'h000100, 24'h000100, 8'd2, 16'd0, 16'd3);
    start = 1'b1;
    cyc(); start = 1'b0;
    cyc(3); cyc(); cyc(3);
    chk("a_last_dwell_meas", 32'(meas_valid), 32'h1);
    chk("a_last_dwell_step", 32'(step_idx), 32'h1);
    d0 = done_cnt; a0 = abort_cnt; abort = 1'b1;
    cyc(); abort = 1'b0;
    chk("a_aborted", 32'(aborted), 32'h1);
    chk("a_nco_off", 32'(nco_en), 32'h0);
    chk("a_meas_off", 32'(meas_valid), 32'h0);
    chk("a_no_done", 32'(done), 32'h0);
    chk("a_busy_off", 32'(busy), 32'h0);
    cyc();
    chk("a_pulse_end", 32'(aborted), 32'h0);
    chk("a_done_count", 32'(done_cnt - d0), 32'h0);
    chk("a_abort_count", 32'(abort_cnt - a0), 32'h1);

    // Reset during the dwell of tone 1, then a clean sweep.
    set_cfg(24'h000100, 24'h000100, 8'd3, 16'd0, 16'd3);
    start = 1'b1;
    cyc(); start = 1'b0;
    cyc(3); cyc(); cyc();
    chk("r_pre_step", 32'(step_idx), 32'h1);
    chk("r_pre_meas", 32'(meas_valid), 32'h1);
    d0 = done_cnt; a0 = abort_cnt;
    #2 reset = 1'b1;
    #1 chk_rst("r_mid");
    cyc(); reset = 1'b0;
    cyc(3);
    chk("r_idle_busy", 32'(busy), 32'h0);
    chk("r_no_done", 32'(done_cnt - d0), 32'h0);
    chk("r_no_abort", 32'(abort_cnt - a0), 32'h0);
    set_cfg(24'h000040, 24'h000040, 8'd2, 16'd0, 16'd1);
    start = 1'b1;
    cyc(); start = 1'b0;
    chk("r2_load_step", 32'(step_idx), 32'h0);
    chk("r2_load_phase", 32'(phase_inc), 32'h000040);
    cyc(); chk("r2_dwell0", 32'(meas_valid), 32'h1);
    cyc(); chk("r2_next_step", 32'(step_idx), 32'h1);
    chk("r2_next_phase", 32'(phase_inc), 32'h000080);
    cyc(2); chk("r2_done", 32'(done), 32'h1);

    // cfg changes and start while busy are ignored.
    cyc(2);
    set_cfg(24'h000010, 24'h000010, 8'd3, 16'd2, 16'd2);
    d0 = done_cnt; start = 1'b1;
    cyc(); start = 1'b0;
    set_cfg(24'h000777, 24'h000999, 8'd7, 16'd0, 16'd9);
    cyc(2); start = 1'b1;
    cyc(); start = 1'b0;
    cyc(2);
    chk("i_phase1", 32'(phase_inc), 32'h000020);
    chk("i_step1", 32'(step_idx), 32'h1);
    cyc(5);
    chk("i_phase2", 32'(phase_inc), 32'h000030);
    chk("i_step2", 32'(step_idx), 32'h2);
    cyc(5); chk("i_done", 32'(done), 32'h1);
    cyc(2);
    chk("i_idle_busy", 32'(busy), 32'h0);
    chk("i_done_count", 32'(done_cnt - d0), 32'h1);

    // start and abort together in IDLE.
    a0 = abort_cnt; start = 1'b1; abort = 1'b1;
    cyc(2);
    chk("sa_busy", 32'(busy), 32'h0);
    chk("sa_abort_count", 32'(abort_cnt - a0), 32'h0);
    start = 1'b0; abort = 1'b0;

    // start held through DONE restarts after one IDLE cycle.
    set_cfg(24'h000123, 24'h000001, 8'd1, 16'd0, 16'd1);
    start = 1'b1;
    cyc(3); chk("h_done", 32'(done), 32'h1);
    cyc(); chk("h_idle_busy", 32'(busy), 32'h0);
    cyc(); chk("h_restart_busy", 32'(busy), 32'h1);
    chk("h_restart_phase", 32'(phase_inc), 32'h000123);
    start = 1'b0; abort = 1'b1;
    cyc(); abort = 1'b0;
    chk("h_aborted", 32'(aborted), 32'h1);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
